rd_pipeline_tracker: RTL and testbench
======================================

# rd_pipeline_tracker

Destination-register tracker for the Core101 decode stage; the producer side of the forwarding unit. It captures each accepted ID instruction's destination register, shifts it through IS, EX and WB slots, and drives the three RD addresses the forwarding unit compares against. It also detects load-use hazards, stalls ID until the load result is forwardable, and counts stall cycles.

## Interface
- Parameters
- STALL_CNT_W, default 16: width of the stall-cycle counter.
- Ports (clock and reset first)
- clock_in  input  1  core clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- id_valid_in  input  1  ID holds a valid instruction.
- id_rd_addr_in  input  5  ID destination register.
- id_wb_en_in  input  1  ID instruction writes rd.
- id_is_load_in  input  1  ID instruction is a load.
- id_rs1_addr_in / id_rs2_addr_in  input  5 each  ID source registers.
- id_rs1_used_in / id_rs2_used_in  input  1 each  the source is actually read.
- hold_in  input  1  global freeze, e.g. a memory wait.
- flush_in  input  1  branch redirect; kills ID, IS and EX.
- rd1_addr_out / rd2_addr_out / rd3_addr_out  output  5 each  destination register in IS / EX / WB.
- stall_out  output  1  load-use stall request to IF/ID.
- stall_cnt_out  output  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- Each slot (IS, EX, WB) holds valid, wb_en, is_load and rd[4:0].
- rdN_addr_out = slot.rd when slot.valid and slot.wb_en, otherwise 5'd0. x0 therefore never forwards.
- Load-use hazard (stall_out = 1) when all of the following hold:
  - id_valid_in = 1.
  - IS or EX holds a valid load with wb_en = 1 and rd != 0.
  - id_rs1_used_in with id_rs1_addr_in == that rd, or id_rs2_used_in with id_rs2_addr_in == that rd.
- A load result is forwardable only from WB.
- stall_out is combinational from slot state and ID inputs, and is forced to 0 while flush_in = 1 or hold_in = 1.
- Per-cycle update, highest priority first:
  - reset_in: all slots invalid, stall_cnt = 0.
  - flush_in: IS and EX become invalid. WB takes the old EX. ID is not captured.
  - hold_in: all slots keep their values.
  - stall_out: IS becomes a bubble (invalid). WB takes EX, EX takes IS. ID is not captured.
  - Normal: WB takes EX, EX takes IS, IS takes the ID fields, with valid = id_valid_in.
- stall_cnt increments each cycle stall_out = 1 and saturates at all-ones. It is cleared only by reset_in.

## Timing
- Reset values: all rd outputs = 0, stall_out = 0, stall_cnt_out = 0.
- An ID instruction accepted in cycle N appears on rd1 in N+1, rd2 in N+2 and rd3 in N+3, with no hold or flush in between.
- A load followed immediately by a dependent instruction gives stall_out = 1 for exactly 2 cycles. With one independent instruction between them, it is 1 cycle.
- hold_in during a stall: slots stay frozen, stall_out is masked to 0 and the counter does not increment. The stall resumes when hold_in drops.
- flush_in during a stall: stall_out = 0 that cycle. The load already in WB still completes.
- Reset mid-operation: the next cycle shows the full reset state, regardless of hold or flush.

## Configuration
- CORE101_LOAD_USE_STALL_EN, defined:
  - hazard detection, stall_out and stall_cnt behave as described above.
- Not defined:
  - stall_out is tied to 0 and stall_cnt_out is tied to 0; no counter register is built.
  - id_is_load_in, the id_rs*_in inputs and the is_load slot bit are ignored.
  - Slots advance only under reset, flush, hold or normal rules.

## Structure
- Shared package core101_pkg holds:
  - REG_ADDR_W = 5 and REG_ZERO = 5'd0.
  - The slot typedef: valid, wb_en, is_load, rd.
- Sub-module rd_slot_reg: one slot register with load, bubble and hold controls. It is instantiated three times.
- Hazard compare and counter stay in the top module.

## Test plan
- Reset then idle: after reset_in, all rdN_addr_out = 0, stall_out = 0 and stall_cnt_out = 0.
- Shift: accept rd = 5 at N, rd = 7 at N+1 (non-loads) -> at N+2 rd1 = 7, rd2 = 5. At N+3 rd2 = 7, rd3 = 5.
- Load-use: load x3, then add reading rs1 = 3 -> stall_out = 1 for 2 cycles, then rd3 = 3. The add enters IS and stall_cnt_out = 2.
- Load to x0 with a dependent reading rs2 = 0 -> no stall, and rd1 = 0 for the load.
- Flush during a stall: load x4 in IS, dependent in ID, flush_in = 1 -> stall_out = 0. The next cycle has rd1 = rd2 = 0, and rd3 shows the old EX rd.
- hold_in for 3 cycles with rd1 = 9, rd2 = 8, rd3 = 6 -> outputs stay unchanged and stall_cnt_out does not change. Saturation check: preload the counter near all-ones, then stall 3 cycles -> it stays at 16'hFFFF.

Source files
------------

// File: rtl/core101_pkg.sv
//------------------------------------------------------------------------------
// Module      : core101_pkg
// Description : Shared register-address constants and pipeline slot type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package core101_pkg;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
  } rd_slot_t;

  // Address a slot presents to forwarding; x0 and non-writers read as zero.
  function automatic logic [REG_ADDR_W-1:0] slot_fwd_rd(input rd_slot_t s);
    return (s.valid && s.wb_en) ? s.rd : REG_ZERO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_slot_reg.sv
//------------------------------------------------------------------------------
// Module      : rd_slot_reg
// Description : One destination-register pipeline slot with load/bubble/hold.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rd_slot_reg
  import core101_pkg::*;
(
  input  logic     clock_in,
  input  logic     reset_in,
  input  logic     load_in,
  input  logic     bubble_in,
  input  rd_slot_t d_in,
  output rd_slot_t q_out
);

  rd_slot_t r_slot;

  // Bubble wins over load; neither asserted means the slot holds.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_slot <= '0;
    end else if (bubble_in) begin
      r_slot <= '0;
    end else if (load_in) begin
      r_slot <= d_in;
    end
  end

  assign q_out = r_slot;

endmodule

`default_nettype wire

// File: rtl/rd_pipeline_tracker.sv
//------------------------------------------------------------------------------
// Module      : rd_pipeline_tracker
// Description : Tracks ID->IS->EX->WB destination registers for forwarding and
//               raises load-use stalls (enabled by CORE101_LOAD_USE_STALL_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rd_pipeline_tracker
  import core101_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   id_valid_in,
  input  logic [REG_ADDR_W-1:0]  id_rd_addr_in,
  input  logic                   id_wb_en_in,
  input  logic                   id_is_load_in,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr_in,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr_in,
  input  logic                   id_rs1_used_in,
  input  logic                   id_rs2_used_in,
  input  logic                   hold_in,
  input  logic                   flush_in,
  output logic [REG_ADDR_W-1:0]  rd1_addr_out,
  output logic [REG_ADDR_W-1:0]  rd2_addr_out,
  output logic [REG_ADDR_W-1:0]  rd3_addr_out,
  output logic                   stall_out,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
);

  rd_slot_t w_id_slot;
  rd_slot_t w_is_slot;
  rd_slot_t w_ex_slot;
  rd_slot_t w_wb_slot;
  logic     w_stall;

  logic w_is_load, w_is_bubble;
  logic w_ex_load, w_ex_bubble;
  logic w_wb_load;

  // stall is already masked by flush/hold, so only flush needs to outrank it.
  assign w_is_bubble = flush_in | w_stall;
  assign w_is_load   = ~flush_in & ~hold_in & ~w_stall;
  assign w_ex_bubble = flush_in;
  assign w_ex_load   = ~hold_in;
  assign w_wb_load   = flush_in | ~hold_in;

  assign w_id_slot.valid = id_valid_in;
  assign w_id_slot.wb_en = id_wb_en_in;
  assign w_id_slot.rd    = id_rd_addr_in;

  rd_slot_reg u_is_slot (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .load_in   (w_is_load),
    .bubble_in (w_is_bubble),
    .d_in      (w_id_slot),
    .q_out     (w_is_slot)
  );

  rd_slot_reg u_ex_slot (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .load_in   (w_ex_load),
    .bubble_in (w_ex_bubble),
    .d_in      (w_is_slot),
    .q_out     (w_ex_slot)
  );

  rd_slot_reg u_wb_slot (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .load_in   (w_wb_load),
    .bubble_in (1'b0),
    .d_in      (w_ex_slot),
    .q_out     (w_wb_slot)
  );

  assign rd1_addr_out = slot_fwd_rd(w_is_slot);
  assign rd2_addr_out = slot_fwd_rd(w_ex_slot);
  assign rd3_addr_out = slot_fwd_rd(w_wb_slot);

  // WB never gates a stall, so its load flag is informational only.
  logic w_unused_wb_load;
  assign w_unused_wb_load = w_wb_slot.is_load;

`ifdef CORE101_LOAD_USE_STALL_EN

  logic                   w_is_hit;
  logic                   w_ex_hit;
  logic                   w_hazard;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_id_slot.is_load = id_is_load_in;

  // A load result only becomes forwardable from WB, so IS and EX loads block.
  assign w_is_hit = w_is_slot.valid && w_is_slot.wb_en && w_is_slot.is_load &&
                    (w_is_slot.rd != REG_ZERO) &&
                    ((id_rs1_used_in && (id_rs1_addr_in == w_is_slot.rd)) ||
                     (id_rs2_used_in && (id_rs2_addr_in == w_is_slot.rd)));

  assign w_ex_hit = w_ex_slot.valid && w_ex_slot.wb_en && w_ex_slot.is_load &&
                    (w_ex_slot.rd != REG_ZERO) &&
                    ((id_rs1_used_in && (id_rs1_addr_in == w_ex_slot.rd)) ||
                     (id_rs2_used_in && (id_rs2_addr_in == w_ex_slot.rd)));

  assign w_hazard = id_valid_in && (w_is_hit || w_ex_hit);
  assign w_stall  = w_hazard && !flush_in && !hold_in;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_out     = w_stall;
  assign stall_cnt_out = r_stall_cnt;

`else

  logic w_unused_hazard_inputs;

  assign w_id_slot.is_load = 1'b0;
  assign w_stall           = 1'b0;
  assign stall_out         = 1'b0;
  assign stall_cnt_out     = '0;

  assign w_unused_hazard_inputs = ^{id_is_load_in, id_rs1_addr_in, id_rs2_addr_in,
                                    id_rs1_used_in, id_rs2_used_in,
                                    w_is_slot.is_load, w_ex_slot.is_load};

`endif

endmodule

`default_nettype wire

// File: tb/tb_rd_pipeline_tracker.sv
//------------------------------------------------------------------------------
// Module      : tb_rd_pipeline_tracker
// Description : Directed self-checking bench for rd_pipeline_tracker.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rd_pipeline_tracker;

`ifdef CORE101_LOAD_USE_STALL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_wb_en, id_is_load, rs1_used, rs2_used;
  logic [4:0] id_rd, rs1, rs2;
  logic       hold, flush;
  logic [4:0] rd1, rd2, rd3, n_rd1, n_rd2, n_rd3;
  logic       stall, n_stall;
  logic [15:0] cnt;
  logic [2:0]  n_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rd_pipeline_tracker #(.STALL_CNT_W(16)) u_dut (
    .clock_in(clk), .reset_in(rst),
    .id_valid_in(id_valid), .id_rd_addr_in(id_rd), .id_wb_en_in(id_wb_en),
    .id_is_load_in(id_is_load), .id_rs1_addr_in(rs1), .id_rs2_addr_in(rs2),
    .id_rs1_used_in(rs1_used), .id_rs2_used_in(rs2_used),
    .hold_in(hold), .flush_in(flush),
    .rd1_addr_out(rd1), .rd2_addr_out(rd2), .rd3_addr_out(rd3),
    .stall_out(stall), .stall_cnt_out(cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  rd_pipeline_tracker #(.STALL_CNT_W(3)) u_dut_sat (
    .clock_in(clk), .reset_in(rst),
    .id_valid_in(id_valid), .id_rd_addr_in(id_rd), .id_wb_en_in(id_wb_en),
    .id_is_load_in(id_is_load), .id_rs1_addr_in(rs1), .id_rs2_addr_in(rs2),
    .id_rs1_used_in(rs1_used), .id_rs2_used_in(rs2_used),
    .hold_in(hold), .flush_in(flush),
    .rd1_addr_out(n_rd1), .rd2_addr_out(n_rd2), .rd3_addr_out(n_rd3),
    .stall_out(n_stall), .stall_cnt_out(n_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic ld,
                        input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2);
    id_valid = v; id_rd = rd; id_wb_en = v; id_is_load = ld;
    rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_rd1", rd1, 0);
    chk("reset_rd2", rd2, 0);
    chk("reset_rd3", rd3, 0);
    chk("reset_stall", stall, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_ncnt", n_cnt, 0);

    // Shift: rd 5 then rd 7
    set_id(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    chk("shift_n2_rd1", rd1, 7);
    chk("shift_n2_rd2", rd2, 5);
    tick();
    chk("shift_n3_rd2", rd2, 7);
    chk("shift_n3_rd3", rd3, 5);
    tick(); tick();
    chk("shift_drain_rd3", rd3, 0);

    // Load-use: ld x3 then add x10 reading x3
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd10, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    chk("lu_stall1", stall, EN);
    chk("lu_rd1_load", rd1, 3);
    tick();
    chk("lu_stall2", stall, EN);
    chk("lu_c2_rd1", rd1, EN ? 0 : 10);
    chk("lu_c2_rd2", rd2, 3);
    tick();
    chk("lu_stall_end", stall, 0);
    chk("lu_rd3", rd3, 3);
    tick();
    idle();
    chk("lu_add_in_is", rd1, 10);
    chk("lu_cnt", cnt, EN ? 2 : 0);
    tick(); tick(); tick();

    // Load to x0 never stalls
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    #1;
    chk("x0_stall", stall, 0);
    chk("x0_rd1", rd1, 0);
    tick();
    idle();
    chk("x0_dep_rd1", rd1, 11);
    tick(); tick(); tick();

    // Flush during a stall
    set_id(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd13, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
    #1;
    chk("fl_prestall", stall, EN);
    flush = 1'b1;
    #1;
    chk("fl_stall_masked", stall, 0);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_rd1", rd1, 0);
    chk("fl_rd2", rd2, 0);
    chk("fl_rd3", rd3, 12);
    chk("fl_cnt", cnt, EN ? 2 : 0);
    tick(); tick();

    // Hold with rd1=9, rd2=8, rd3=6
    set_id(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    hold = 1'b1;
    tick(); tick(); tick();
    chk("hold_rd1", rd1, 9);
    chk("hold_rd2", rd2, 8);
    chk("hold_rd3", rd3, 6);
    chk("hold_cnt", cnt, EN ? 2 : 0);
    hold = 1'b0;
    idle();
    tick(); tick(); tick();

    // Hold during a stall
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd14, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    hold = 1'b1;
    #1;
    chk("hs_stall_masked", stall, 0);
    tick(); tick();
    chk("hs_rd1_frozen", rd1, 5);
    chk("hs_cnt_frozen", cnt, EN ? 2 : 0);
    hold = 1'b0;
    #1;
    chk("hs_stall_resume", stall, EN);
    tick(); tick();
    chk("hs_stall_done", stall, 0);
    chk("hs_rd3", rd3, 5);
    chk("hs_cnt", cnt, EN ? 4 : 0);
    tick();
    idle();
    tick(); tick(); tick();

    // Saturation: three more load-use pairs (+2 stall cycles each)
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      set_id(1'b1, 5'd10, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
      tick(); tick(); tick();
      idle();
      if (i == 1) begin
        chk("sat_cnt_8", cnt, EN ? 8 : 0);
        chk("sat_ncnt_7", n_cnt, EN ? 7 : 0);
      end
    end
    chk("sat_cnt_10", cnt, EN ? 10 : 0);
    chk("sat_ncnt_hold", n_cnt, EN ? 7 : 0);

    // Reset mid-operation with hold and flush asserted
    chk("pre_rst_rd1", rd1, 10);
    set_id(1'b1, 5'd15, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0);
    rst = 1'b1; hold = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    idle();
    #1;
    chk("mrst_rd1", rd1, 0);
    chk("mrst_rd2", rd2, 0);
    chk("mrst_rd3", rd3, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_ncnt", n_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
